// File: rtl/bid_pkg.sv
// Shared definitions for the bid controller command interface and the host sequencer.
package bid_pkg;

   // Controller opcodes (encoding shared with the bid controller)
   typedef enum logic [3:0] {
      OP_NOP        = 4'd0,
      OP_UNLOCK     = 4'd1,
      OP_LOCK       = 4'd2,
      OP_LOAD_X     = 4'd3,
      OP_LOAD_Y     = 4'd4,
      OP_LOAD_Z     = 4'd5,
      OP_SET_MASK   = 4'd6,
      OP_SET_TIMER  = 4'd7,
      OP_BID_CHARGE = 4'd8
   } opcode_e;

   // Controller error codes, plus the sequencer's own timeout code
   localparam logic [2:0] ERR_OK             = 3'd0;
   localparam logic [2:0] ERR_BADKEY         = 3'd1;
   localparam logic [2:0] ERR_UNLOCKED       = 3'd2;
   localparam logic [2:0] ERR_START_UNLOCKED = 3'd3;
   localparam logic [2:0] ERR_INVALID        = 3'd4;
   localparam logic [2:0] FAULT_TIMEOUT      = 3'b111;

   // Number of programming ops issued per configuration
   localparam int CFG_STEPS = 7;

   // Which latched configuration field drives C_data
   typedef enum logic [2:0] {
      SEL_ZERO, SEL_X, SEL_Y, SEL_Z, SEL_MASK, SEL_TIMER, SEL_COST, SEL_KEY
   } dsel_e;

   typedef enum logic [2:0] {
      S_IDLE, S_CFG, S_ROUND, S_WAIT_RO, S_RESULT, S_UNLOCK, S_DONE, S_FAULT
   } seq_state_e;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic [2:0]  mask;
      logic [3:0]  timer;
      logic [31:0] cost;
      logic [31:0] key;
   } bid_cfg_t;

   // Operand for a programming op; narrow fields are zero-extended
   function automatic logic [31:0] cfg_field(input bid_cfg_t c, input dsel_e s);
      case (s)
         SEL_X:     return c.x;
         SEL_Y:     return c.y;
         SEL_Z:     return c.z;
         SEL_MASK:  return {29'd0, c.mask};
         SEL_TIMER: return {28'd0, c.timer};
         SEL_COST:  return c.cost;
         SEL_KEY:   return c.key;
         default:   return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/bid_op_rom.sv
// Programming-step table: step index 0..6 to opcode and operand source.
module bid_op_rom
   import bid_pkg::*;
(
   input  logic [2:0] step,
   output opcode_e    op,
   output dsel_e      sel
);

   // Fixed programming order; the lock op goes last so loads land while unlocked
   always_comb begin
      op  = OP_NOP;
      sel = SEL_ZERO;
      case (step)
         3'd0: begin op = OP_LOAD_X;     sel = SEL_X;     end
         3'd1: begin op = OP_LOAD_Y;     sel = SEL_Y;     end
         3'd2: begin op = OP_LOAD_Z;     sel = SEL_Z;     end
         3'd3: begin op = OP_SET_MASK;   sel = SEL_MASK;  end
         3'd4: begin op = OP_SET_TIMER;  sel = SEL_TIMER; end
         3'd5: begin op = OP_BID_CHARGE; sel = SEL_COST;  end
         3'd6: begin op = OP_LOCK;       sel = SEL_KEY;   end
         default: ;
      endcase
   end

endmodule

// File: rtl/bid_host_sequencer.sv
// Host-side initiator: programs the bid controller, runs N rounds, returns results, unlocks.
module bid_host_sequencer
   import bid_pkg::*;
#(
   parameter int BID_WINDOW = 4,
   parameter int RO_TIMEOUT = 16,
   parameter int RW         = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [31:0]   cfg_x,
   input  logic [31:0]   cfg_y,
   input  logic [31:0]   cfg_z,
   input  logic [2:0]    cfg_mask,
   input  logic [3:0]    cfg_timer,
   input  logic [31:0]   cfg_cost,
   input  logic [31:0]   cfg_key,
   input  logic [RW-1:0] cfg_rounds,
   output logic [3:0]    C_op,
   output logic [31:0]   C_data,
   output logic          C_start,
   input  logic          bc_ready,
   input  logic [2:0]    bc_err,
   input  logic          bc_roundOver,
   input  logic [2:0]    bc_win,
   input  logic [31:0]   bc_maxBid,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [RW-1:0] res_round,
   output logic [2:0]    res_win,
   output logic [31:0]   res_maxBid,
   output logic          busy,
   output logic          done,
   output logic          fault,
   output logic [2:0]    fault_code
);

   localparam int            CW        = 16;
   localparam logic [CW-1:0] BW_LAST   = CW'(BID_WINDOW - 1);
   localparam logic [CW-1:0] RO_LIMIT  = CW'(RO_TIMEOUT);
   localparam logic [CW-1:0] CFG_LAST  = CW'(CFG_STEPS - 1);

   seq_state_e    state_q, state_d;
   bid_cfg_t      cfg_q, cfg_d;
   logic [RW-1:0] rounds_q, rounds_d;
   logic [RW-1:0] round_q, round_d;
   logic [RW-1:0] next_round;
   logic [CW-1:0] cnt_q, cnt_d;
   opcode_e       c_op_q, c_op_d;
   logic [31:0]   c_data_q, c_data_d;
   logic          c_start_q, c_start_d;
   logic          op_vld_q, op_vld_d;
   logic          err_chk_q, err_chk_d;
   logic          cfg_ready_q, cfg_ready_d;
   logic          res_valid_q, res_valid_d;
   logic [2:0]    res_win_q, res_win_d;
   logic [31:0]   res_max_q, res_max_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          fault_q, fault_d;
   logic [2:0]    fault_code_q, fault_code_d;
   opcode_e       rom_op;
   dsel_e         rom_sel;

   bid_op_rom u_rom (
      .step (cnt_q[2:0]),
      .op   (rom_op),
      .sel  (rom_sel)
   );

   assign next_round = round_q + 1'b1;

   // Next-state and next-output logic; outputs are registered so the controller sees clean ops
   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      rounds_d     = rounds_q;
      round_d      = round_q;
      cnt_d        = cnt_q;
      c_op_d       = OP_NOP;
      c_data_d     = 32'd0;
      c_start_d    = 1'b0;
      op_vld_d     = 1'b0;
      err_chk_d    = op_vld_q;
      res_valid_d  = res_valid_q;
      res_win_d    = res_win_q;
      res_max_d    = res_max_q;
      done_d       = 1'b0;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;

      case (state_q)
         S_IDLE: begin
            if (cfg_valid && cfg_ready_q) begin
               cfg_d.x      = cfg_x;
               cfg_d.y      = cfg_y;
               cfg_d.z      = cfg_z;
               cfg_d.mask   = cfg_mask;
               cfg_d.timer  = cfg_timer;
               cfg_d.cost   = cfg_cost;
               cfg_d.key    = cfg_key;
               rounds_d     = cfg_rounds;
               round_d      = '0;
               cnt_d        = '0;
               fault_d      = 1'b0;
               fault_code_d = ERR_OK;
               state_d      = S_CFG;
            end
         end
         S_CFG: begin
            c_op_d   = rom_op;
            c_data_d = cfg_field(cfg_q, rom_sel);
            op_vld_d = 1'b1;
            if (cnt_q == CFG_LAST) begin
               cnt_d   = '0;
               state_d = (rounds_q == '0) ? S_UNLOCK : S_ROUND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ROUND: begin
            c_start_d = 1'b1;
            if (cnt_q == BW_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT_RO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_RO: begin
            // Counting starts on the last strobe cycle, so the limit lands
            // RO_TIMEOUT cycles after C_start has actually dropped
            if (bc_roundOver) begin
               res_valid_d = 1'b1;
               res_win_d   = bc_win;
               res_max_d   = bc_maxBid;
               cnt_d       = '0;
               state_d     = S_RESULT;
            end else if (cnt_q == RO_LIMIT) begin
               fault_d      = 1'b1;
               fault_code_d = FAULT_TIMEOUT;
               cnt_d        = '0;
               state_d      = S_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESULT: begin
            // Controller relocks and flags an error while we stall; that is expected
            if (res_ready) begin
               res_valid_d = 1'b0;
               round_d     = next_round;
               cnt_d       = '0;
               state_d     = (next_round == rounds_q) ? S_UNLOCK : S_ROUND;
            end
         end
         S_UNLOCK: begin
            // cnt 0 drives Unlock, cnt 1 lets its error settle, cnt 2 is the check
            if (cnt_q == '0) begin
               c_op_d   = OP_UNLOCK;
               c_data_d = cfg_q.key;
               op_vld_d = 1'b1;
               cnt_d    = cnt_q + 1'b1;
            end else if (cnt_q == CW'(1)) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Error from the op driven on the previous cycle aborts the sequence
      if (err_chk_q && (bc_err != ERR_OK) &&
          (state_q inside {S_CFG, S_ROUND, S_WAIT_RO, S_UNLOCK})) begin
         state_d      = S_FAULT;
         c_op_d       = OP_NOP;
         c_data_d     = 32'd0;
         c_start_d    = 1'b0;
         op_vld_d     = 1'b0;
         err_chk_d    = 1'b0;
         done_d       = 1'b0;
         res_valid_d  = 1'b0;
         cnt_d        = '0;
         fault_d      = 1'b1;
         fault_code_d = bc_err;
      end

      busy_d      = !(state_d inside {S_IDLE, S_DONE, S_FAULT});
      cfg_ready_d = (state_d == S_IDLE) && bc_ready;
   end

   // State and registered outputs; reset clears everything, including C_start, at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cfg_q        <= '0;
         rounds_q     <= '0;
         round_q      <= '0;
         cnt_q        <= '0;
         c_op_q       <= OP_NOP;
         c_data_q     <= 32'd0;
         c_start_q    <= 1'b0;
         op_vld_q     <= 1'b0;
         err_chk_q    <= 1'b0;
         cfg_ready_q  <= 1'b0;
         res_valid_q  <= 1'b0;
         res_win_q    <= 3'd0;
         res_max_q    <= 32'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         rounds_q     <= rounds_d;
         round_q      <= round_d;
         cnt_q        <= cnt_d;
         c_op_q       <= c_op_d;
         c_data_q     <= c_data_d;
         c_start_q    <= c_start_d;
         op_vld_q     <= op_vld_d;
         err_chk_q    <= err_chk_d;
         cfg_ready_q  <= cfg_ready_d;
         res_valid_q  <= res_valid_d;
         res_win_q    <= res_win_d;
         res_max_q    <= res_max_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign cfg_ready  = cfg_ready_q;
   assign C_op       = c_op_q;
   assign C_data     = c_data_q;
   assign C_start    = c_start_q;
   assign res_valid  = res_valid_q;
   assign res_round  = round_q;
   assign res_win    = res_win_q;
   assign res_maxBid = res_max_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_bid_host_sequencer.sv
// Directed bench for bid_host_sequencer with a small controller model and result scoreboard.
module tb_bid_host_sequencer;

   localparam int BID_WINDOW = 4;
   localparam int RO_TIMEOUT = 16;
   localparam int RW         = 8;

   typedef struct packed {
      logic [7:0]  round;
      logic [2:0]  win;
      logic [31:0] max;
   } rec_t;

   logic          clk;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [31:0]   cfg_x, cfg_y, cfg_z, cfg_cost, cfg_key;
   logic [2:0]    cfg_mask;
   logic [3:0]    cfg_timer;
   logic [RW-1:0] cfg_rounds;
   logic [3:0]    C_op;
   logic [31:0]   C_data;
   logic          C_start;
   logic          bc_ready;
   logic [2:0]    bc_err;
   logic          bc_roundOver;
   logic [2:0]    bc_win;
   logic [31:0]   bc_maxBid;
   logic          res_valid;
   logic          res_ready;
   logic [RW-1:0] res_round;
   logic [2:0]    res_win;
   logic [31:0]   res_maxBid;
   logic          busy, done, fault;
   logic [2:0]    fault_code;

   int   tests = 0;
   int   fails = 0;
   int   n_rec = 0;
   rec_t sb_q[$];

   // controller model knobs
   logic [3:0] inj_op = 4'd0;
   bit         ro_en = 1'b1;
   int         mdl_round = 0;
   int         salt = 0;

   bid_host_sequencer #(
      .BID_WINDOW (BID_WINDOW),
      .RO_TIMEOUT (RO_TIMEOUT),
      .RW         (RW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_x        (cfg_x),
      .cfg_y        (cfg_y),
      .cfg_z        (cfg_z),
      .cfg_mask     (cfg_mask),
      .cfg_timer    (cfg_timer),
      .cfg_cost     (cfg_cost),
      .cfg_key      (cfg_key),
      .cfg_rounds   (cfg_rounds),
      .C_op         (C_op),
      .C_data       (C_data),
      .C_start      (C_start),
      .bc_ready     (bc_ready),
      .bc_err       (bc_err),
      .bc_roundOver (bc_roundOver),
      .bc_win       (bc_win),
      .bc_maxBid    (bc_maxBid),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_round    (res_round),
      .res_win      (res_win),
      .res_maxBid   (res_maxBid),
      .busy         (busy),
      .done         (done),
      .fault        (fault),
      .fault_code   (fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return cfg_ready;
         1:       return C_start;
         2:       return !C_start;
         3:       return res_valid;
         4:       return done;
         5:       return fault;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int budget);
      int n = 0;
      @(negedge clk);
      while (!sig(sel) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(sig(sel)), 64'd1);
   endtask

   task automatic wait_op(input string tag, input logic [3:0] op, input int budget);
      int n = 0;
      @(negedge clk);
      while (C_op !== op && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(C_op), 64'(op));
   endtask

   task automatic start_cfg(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                            input logic [2:0] m, input logic [3:0] t, input logic [31:0] cost,
                            input logic [31:0] key, input logic [7:0] r);
      wait_for("cfg_ready", 0, 40);
      mdl_round = 0;
      @(posedge clk); #1;
      cfg_valid  = 1'b1;
      cfg_x      = x;
      cfg_y      = y;
      cfg_z      = z;
      cfg_mask   = m;
      cfg_timer  = t;
      cfg_cost   = cost;
      cfg_key    = key;
      cfg_rounds = r;
      @(posedge clk); #1;
      cfg_valid  = 1'b0;
   endtask

   // Controller model: error follows the op by one cycle, err=4 while results stall,
   // roundOver pulses the cycle after C_start has been seen low
   initial begin : ctrl_model
      logic [3:0] op_s;
      logic       rv_s, cs_s, cs_prev, ro_pend;
      rec_t       r;
      cs_prev = 1'b0;
      ro_pend = 1'b0;
      bc_ready = 1'b1;
      bc_err = 3'd0;
      bc_roundOver = 1'b0;
      bc_win = 3'd0;
      bc_maxBid = 32'd0;
      forever begin
         @(negedge clk);
         op_s = C_op;
         rv_s = res_valid;
         cs_s = C_start;
         if (reset) begin
            cs_prev = 1'b0;
            ro_pend = 1'b0;
         end else begin
            if (cs_prev && !cs_s && ro_en) ro_pend = 1'b1;
            cs_prev = cs_s;
         end
         @(posedge clk); #1;
         bc_err = (inj_op != 4'd0 && op_s == inj_op) ? 3'd3 : (rv_s ? 3'd4 : 3'd0);
         bc_roundOver = 1'b0;
         if (ro_pend) begin
            ro_pend      = 1'b0;
            bc_roundOver = 1'b1;
            bc_win       = 3'b001 << (mdl_round % 3);
            bc_maxBid    = 32'(1000 + salt + mdl_round * 17);
            r.round      = 8'(mdl_round);
            r.win        = bc_win;
            r.max        = bc_maxBid;
            sb_q.push_back(r);
            mdl_round++;
         end
      end
   end

   // Result monitor: every accepted record must match the oldest expected one
   initial begin : res_monitor
      rec_t e;
      forever begin
         @(negedge clk);
         if (!reset && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
               check("res_unexpected", 64'd0, 64'd1);
            end else begin
               e = sb_q.pop_front();
               check("res_record", {21'd0, res_round, res_win, res_maxBid},
                     {21'd0, e.round, e.win, e.max});
               n_rec++;
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: time limit reached before the sequence finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [3:0]  exp_op [7];
      logic [31:0] exp_dt [7];
      int n, run, wins, bad, hits;
      bit seen;

      reset = 1'b1;
      cfg_valid = 1'b0;
      cfg_x = '0; cfg_y = '0; cfg_z = '0; cfg_cost = '0; cfg_key = '0;
      cfg_mask = '0; cfg_timer = '0; cfg_rounds = '0;
      res_ready = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_C_op", 64'(C_op), 64'd0);
      check("rst_C_start", 64'(C_start), 64'd0);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
      check("rst_busy_done_fault", {61'd0, busy, done, fault}, 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("cfg_ready_before_clock", 64'(cfg_ready), 64'd0);
      @(negedge clk);
      check("cfg_ready_after_clock", 64'(cfg_ready), 64'd1);

      // single round, full op sequence
      exp_op = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
      exp_dt = '{32'd100, 32'd200, 32'd300, 32'd7, 32'd3, 32'd1, 32'h0000A5A5};
      salt = 0;
      start_cfg(32'd100, 32'd200, 32'd300, 3'd7, 4'd3, 32'd1, 32'h0000A5A5, 8'd1);
      check("t1_busy", 64'(busy), 64'd1);
      wait_op("t1_first_op", 4'd3, 10);
      check("t1_data_0", 64'(C_data), 64'(exp_dt[0]));
      for (int i = 1; i < 7; i++) begin
         @(negedge clk);
         check($sformatf("t1_op_%0d", i), 64'(C_op), 64'(exp_op[i]));
         check($sformatf("t1_data_%0d", i), 64'(C_data), 64'(exp_dt[i]));
      end
      wait_for("t1_start_rise", 1, 10);
      run = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!C_start) break;
         run++;
      end
      check("t1_start_len", 64'(run), 64'(BID_WINDOW));
      wait_op("t1_unlock", 4'd1, 40);
      check("t1_unlock_key", 64'(C_data), 64'h0000A5A5);
      wait_for("t1_done", 4, 10);
      check("t1_no_fault", {62'd0, fault, busy}, 64'd0);
      @(negedge clk);
      check("t1_done_pulse", 64'(done), 64'd0);
      check("t1_records", 64'(n_rec), 64'd1);

      // three rounds, results consumed immediately
      salt = 500;
      start_cfg(32'd10, 32'd20, 32'd30, 3'd5, 4'd2, 32'd4, 32'h12345678, 8'd3);
      n = 0; run = 0; wins = 0; bad = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
         if (C_start) run++;
         else if (run != 0) begin
            wins++;
            if (run != BID_WINDOW) bad++;
            run = 0;
         end
      end
      check("t2_done", 64'(done), 64'd1);
      check("t2_windows", 64'(wins), 64'd3);
      check("t2_window_len_errors", 64'(bad), 64'd0);
      check("t2_records", 64'(n_rec), 64'd4);

      // result stall with controller reporting err=4
      salt = 2000;
      res_ready = 1'b0;
      start_cfg(32'd1, 32'd2, 32'd3, 3'd1, 4'd1, 32'd9, 32'h0BADF00D, 8'd1);
      wait_for("t3_res_valid", 3, 60);
      check("t3_sb_depth", 64'(sb_q.size()), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_valid", 64'(res_valid), 64'd1);
         if (sb_q.size() != 0)
            check("t3_hold_payload", {21'd0, res_round, res_win, res_maxBid},
                  {21'd0, sb_q[0].round, sb_q[0].win, sb_q[0].max});
         check("t3_hold_bus", {59'd0, C_op, C_start}, 64'd0);
         check("t3_hold_no_fault", 64'(fault), 64'd0);
      end
      check("t3_ctrl_err_seen", 64'(bc_err), 64'd4);
      @(posedge clk); #1;
      res_ready = 1'b1;
      wait_for("t3_done", 4, 30);
      check("t3_no_fault", 64'(fault), 64'd0);
      check("t3_records", 64'(n_rec), 64'd5);

      // controller error after LoadY aborts programming
      inj_op = 4'd4;
      start_cfg(32'd7, 32'd8, 32'd9, 3'd3, 4'd5, 32'd2, 32'h00C0FFEE, 8'd2);
      n = 0; seen = 1'b0;
      while (!fault && n < 30) begin
         @(negedge clk);
         n++;
         if (C_op == 4'd6) seen = 1'b1;
      end
      check("t4_fault", 64'(fault), 64'd1);
      check("t4_fault_code", 64'(fault_code), 64'd3);
      check("t4_no_setmask", 64'(seen), 64'd0);
      check("t4_busy", 64'(busy), 64'd0);
      hits = 0;
      for (int i = 0; i < 4; i++) begin
         if (C_op != 4'd0 || C_start) hits++;
         @(negedge clk);
      end
      check("t4_bus_quiet", 64'(hits), 64'd0);
      inj_op = 4'd0;
      check("t4_cfg_ready_back", 64'(cfg_ready), 64'd1);
      check("t4_fault_sticky", 64'(fault), 64'd1);

      // roundOver never arrives
      ro_en = 1'b0;
      start_cfg(32'd5, 32'd6, 32'd7, 3'd7, 4'd4, 32'd3, 32'h00001111, 8'd1);
      @(negedge clk);
      check("t5_fault_cleared", {61'd0, fault, fault_code}, 64'd0);
      wait_for("t5_start_rise", 1, 20);
      wait_for("t5_start_fall", 2, 20);
      n = 0;
      while (!fault && n < RO_TIMEOUT + 10) begin
         @(negedge clk);
         n++;
      end
      check("t5_timeout_delay", 64'(n), 64'(RO_TIMEOUT));
      check("t5_fault_code", 64'(fault_code), 64'd7);
      ro_en = 1'b1;

      // zero rounds: Lock then Unlock back to back
      start_cfg(32'd11, 32'd22, 32'd33, 3'd2, 4'd6, 32'd5, 32'h5A5A0001, 8'd0);
      wait_op("t6_lock", 4'd2, 20);
      check("t6_lock_key", 64'(C_data), 64'h5A5A0001);
      @(negedge clk);
      check("t6_unlock_next", 64'(C_op), 64'd1);
      check("t6_unlock_key", 64'(C_data), 64'h5A5A0001);
      n = 0; hits = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         if (C_start) hits++;
      end
      check("t6_done", 64'(done), 64'd1);
      check("t6_no_start", 64'(hits), 64'd0);
      check("t6_no_fault", 64'(fault), 64'd0);

      // reset in the middle of a bid window
      start_cfg(32'd1, 32'd1, 32'd1, 3'd7, 4'd1, 32'd1, 32'h00000042, 8'd1);
      wait_for("t7_start_rise", 1, 20);
      #1;
      reset = 1'b1;
      #1;
      check("t7_start_async_drop", 64'(C_start), 64'd0);
      check("t7_busy_cleared", 64'(busy), 64'd0);
      check("t7_cfg_ready_cleared", 64'(cfg_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("t7_ready_before_clock", 64'(cfg_ready), 64'd0);
      @(negedge clk);
      check("t7_ready_after_clock", 64'(cfg_ready), 64'd1);

      // recovery run after reset
      salt = 7000;
      start_cfg(32'd3, 32'd4, 32'd5, 3'd6, 4'd2, 32'd1, 32'h00007777, 8'd2);
      wait_for("t8_done", 4, 200);
      check("t8_records", 64'(n_rec), 64'd7);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
